// File: rtl/as_pack.sv
// Shared TAP types and constants for the JTAG instruction-memory loader.
// Imported by the TAP state machine and the I-Mem scan top.
package as_pack;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

  localparam int         TAP_IR_WIDTH   = 8;
  localparam logic [7:0] TAP_IMEM_OPC   = 8'h80;
  localparam logic [7:0] TAP_BYPASS_OPC = 8'hFF;

  function automatic int im_scan_length(
    input int aw,
    input int iw
  );
    return aw + iw + 1;
  endfunction

endpackage

// File: rtl/as_tap_fsm.sv
// IEEE 1149.1 TAP state machine, driven purely by TMS.
// Kept separate so other scan chains can reuse it.
module as_tap_fsm
  import as_pack::*;
(
  input  logic       tck_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output tap_state_t state_o
);

  tap_state_t state_q, state_d;

  always_ff @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) state_q <= TLR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms_i ? TLR    : RTI;
      RTI:     state_d = tms_i ? SEL_DR : RTI;
      SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
      SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tms_i ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = tms_i ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
      SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
      CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
      SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tms_i ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = tms_i ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/as_jtag_tap_imem.sv
// JTAG TAP with an {addr, instr, we} scan register that issues
// one-TCK instruction-memory write strobes on Update-DR.
module as_jtag_tap_imem
  import as_pack::*;
#(
  parameter int                    IR_WIDTH        = TAP_IR_WIDTH,
  parameter int                    IMEM_ADDR_WIDTH = 12,
  parameter int                    INSTR_WIDTH     = 32,
  parameter logic [IR_WIDTH-1:0]   IMEM_OPC        = TAP_IMEM_OPC,
  parameter logic [IR_WIDTH-1:0]   BYPASS_OPC      = TAP_BYPASS_OPC
) (
  input  logic                       tck_i,
  input  logic                       trst_i,
  input  logic                       tms_i,
  input  logic                       tdi_i,
  output logic                       tdo_o,
  output logic [IMEM_ADDR_WIDTH-1:0] im_addr_o,
  output logic [INSTR_WIDTH-1:0]     im_data_o,
  output logic                       im_we_o,
  output logic                       imem_sel_o
);

  localparam int L = im_scan_length(IMEM_ADDR_WIDTH, INSTR_WIDTH);

  tap_state_t st;

  logic [IR_WIDTH-1:0]        ir_sh_q, ir_sh_d;
  logic [IR_WIDTH-1:0]        ir_q, ir_d;
  logic                       sel_q;
  logic                       byp_q, byp_d;
  logic [L-1:0]               dr_q, dr_d;
  logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INSTR_WIDTH-1:0]     data_q, data_d;
  logic                       we_q, we_d;
  logic                       tdo_q, tdo_d;

  as_tap_fsm u_fsm (
    .tck_i   (tck_i),
    .trst_i  (trst_i),
    .tms_i   (tms_i),
    .state_o (st)
  );

  always_comb begin
    ir_sh_d = ir_sh_q;
    ir_d    = ir_q;
    byp_d   = byp_q;
    dr_d    = dr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    case (st)
      TLR:    ir_d    = BYPASS_OPC;
      CAP_IR: ir_sh_d = {{(IR_WIDTH-1){1'b0}}, 1'b1};
      SH_IR:  ir_sh_d = {ir_sh_q[IR_WIDTH-2:0], tdi_i};
      UPD_IR: ir_d    = ir_sh_q;
      CAP_DR: begin
        if (sel_q) dr_d  = {addr_q, data_q, 1'b0};
        else       byp_d = 1'b0;
      end
      SH_DR: begin
        if (sel_q) dr_d  = {dr_q[L-2:0], tdi_i};
        else       byp_d = tdi_i;
      end
      UPD_DR: begin
        if (sel_q) begin
          addr_d = dr_q[L-1 -: IMEM_ADDR_WIDTH];
          data_d = dr_q[INSTR_WIDTH:1];
          we_d   = dr_q[0];
        end
      end
      default: ;
    endcase
  end

  // sel_q is compared against the next IR so it moves with ir_q
  always_ff @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) begin
      ir_sh_q <= '0;
      ir_q    <= BYPASS_OPC;
      sel_q   <= 1'b0;
      byp_q   <= 1'b0;
      dr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      ir_sh_q <= ir_sh_d;
      ir_q    <= ir_d;
      sel_q   <= (ir_d == IMEM_OPC);
      byp_q   <= byp_d;
      dr_q    <= dr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    tdo_d = 1'b0;
    if (st == SH_IR)      tdo_d = ir_sh_q[IR_WIDTH-1];
    else if (st == SH_DR) tdo_d = sel_q ? dr_q[L-1] : byp_q;
  end

  always_ff @(negedge tck_i or negedge trst_i) begin
    if (!trst_i) tdo_q <= 1'b0;
    else         tdo_q <= tdo_d;
  end

  assign tdo_o      = tdo_q;
  assign im_addr_o  = addr_q;
  assign im_data_o  = data_q;
  assign im_we_o    = we_q;
  assign imem_sel_o = sel_q;

endmodule

// File: tb/tb_as_jtag_tap_imem.sv
// Directed bench for the JTAG I-Mem TAP: queue-based TAP model
// compared every cycle, plus hand-computed literal expectations.
module tb_as_jtag_tap_imem;

  logic        tck_i = 1'b0;
  logic        trst_i = 1'b0;
  logic        tms_i = 1'b1;
  logic        tdi_i = 1'b0;
  logic        tdo_o;
  logic [11:0] im_addr_o;
  logic [31:0] im_data_o;
  logic        im_we_o;
  logic        imem_sel_o;

  as_jtag_tap_imem dut (
    .tck_i      (tck_i),
    .trst_i     (trst_i),
    .tms_i      (tms_i),
    .tdi_i      (tdi_i),
    .tdo_o      (tdo_o),
    .im_addr_o  (im_addr_o),
    .im_data_o  (im_data_o),
    .im_we_o    (im_we_o),
    .imem_sel_o (imem_sel_o)
  );

  always #5 tck_i = ~tck_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // TAP states by index, with next-state tables for TMS=0 / TMS=1
  // 0 TLR 1 RTI 2 SDR 3 CDR 4 SHDR 5 E1DR 6 PDR 7 E2DR 8 UDR
  // 9 SIR 10 CIR 11 SHIR 12 E1IR 13 PIR 14 E2IR 15 UIR
  int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_st;
  logic [7:0]  m_ir;
  bit          q_ir[$];
  bit          q_dr[$];
  logic [11:0] m_addr;
  logic [31:0] m_data;
  bit          m_we;

  function automatic logic [63:0] q2v(input bit q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) v = {v[62:0], q[i]};
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_ir = 8'hFF;
    q_ir.delete();
    repeat (8) q_ir.push_back(1'b0);
    q_dr.delete();
    q_dr.push_back(1'b0);
    m_addr = '0;
    m_data = '0;
    m_we = 1'b0;
  endtask

  task automatic model_step(input bit tms, input bit tdi);
    bit          nwe = 1'b0;
    logic [63:0] v;
    case (m_st)
      0: m_ir = 8'hFF;
      10: begin
        q_ir.delete();
        for (int i = 7; i >= 0; i--) q_ir.push_back(i == 0);
      end
      11: begin
        void'(q_ir.pop_front());
        q_ir.push_back(tdi);
      end
      15: begin
        v = q2v(q_ir);
        m_ir = v[7:0];
      end
      3: begin
        q_dr.delete();
        if (m_ir == 8'h80) begin
          v = {19'd0, m_addr, m_data, 1'b0};
          for (int i = 44; i >= 0; i--) q_dr.push_back(v[i]);
        end else q_dr.push_back(1'b0);
      end
      4: begin
        void'(q_dr.pop_front());
        q_dr.push_back(tdi);
      end
      8: if (m_ir == 8'h80) begin
        v = q2v(q_dr);
        m_addr = v[44:33];
        m_data = v[32:1];
        nwe = v[0];
      end
      default: ;
    endcase
    m_we = nwe;
    m_st = tms ? nx1[m_st] : nx0[m_st];
  endtask

  always @(posedge tck_i or negedge trst_i) begin
    if (!trst_i) model_reset();
    else         model_step(tms_i, tdi_i);
  end

  function automatic bit exp_tdo();
    if (m_st == 11) return q_ir[0];
    if (m_st == 4)  return q_dr[0];
    return 1'b0;
  endfunction

  int cyc = 0;
  always @(posedge tck_i) cyc++;

  int pulses = 0;
  int last_pulse = 0;
  bit prev_we = 1'b0;

  always @(negedge tck_i) begin
    #2;
    chk("tdo", 64'(tdo_o), 64'(exp_tdo()));
    chk("we", 64'(im_we_o), 64'(m_we));
    chk("addr", 64'(im_addr_o), 64'(m_addr));
    chk("data", 64'(im_data_o), 64'(m_data));
    chk("sel", 64'(imem_sel_o), 64'(m_ir == 8'h80));
    if (prev_we) chk("we_width", 64'(im_we_o), 64'd0);
    if (im_we_o && !prev_we) begin
      pulses++;
      if (pulses > 1) chk("we_gap_ge48", 64'(cyc - last_pulse >= 48), 64'd1);
      last_pulse = cyc;
    end
    prev_we = im_we_o;
  end

  logic        tdo_s;
  logic [63:0] tdo_cap;

  task automatic clk(input bit tms, input bit tdi);
    tms_i = tms;
    tdi_i = tdi;
    @(negedge tck_i);
    #1;
    tdo_s = tdo_o;
    @(posedge tck_i);
    #1;
  endtask

  task automatic shift_bits(input logic [63:0] val, input int n,
                            input bit ex);
    for (int i = n - 1; i >= 0; i--) begin
      clk(ex && i == 0, val[i]);
      tdo_cap = {tdo_cap[62:0], tdo_s};
    end
  endtask

  task automatic ir_load80();
    clk(1, 0);
    clk(1, 0);
    clk(0, 0);
    clk(0, 1);
    shift_bits(64'd0, 7, 1);
    clk(1, 0);
    clk(0, 0);
  endtask

  task automatic dr_frame(input logic [44:0] v, input bit from_sel,
                          input bit to_sel);
    if (!from_sel) clk(1, 0);
    clk(0, 0);
    clk(0, 0);
    shift_bits(64'(v), 45, 1);
    clk(1, 0);
    clk(to_sel, 0);
  endtask

  logic [63:0] vv;

  initial begin
    repeat (2) @(posedge tck_i);
    #1;
    chk("rst_addr", 64'(im_addr_o), 64'h0);
    chk("rst_data", 64'(im_data_o), 64'h0);
    chk("rst_we", 64'(im_we_o), 64'h0);
    chk("rst_sel", 64'(imem_sel_o), 64'h0);
    chk("rst_tdo", 64'(tdo_o), 64'h0);
    trst_i = 1'b1;
    clk(0, 0);

    ir_load80();
    chk("ir_sel", 64'(imem_sel_o), 64'h1);

    dr_frame({12'hFF0, 32'hAAAAAAAA, 1'b1}, 0, 1);
    chk("f1_we", 64'(im_we_o), 64'h1);
    chk("f1_addr", 64'(im_addr_o), 64'hFF0);
    chk("f1_data", 64'(im_data_o), 64'hAAAAAAAA);
    dr_frame({12'hFF4, 32'h55555555, 1'b1}, 1, 0);
    chk("f2_we", 64'(im_we_o), 64'h1);
    chk("f2_addr", 64'(im_addr_o), 64'hFF4);
    chk("f2_data", 64'(im_data_o), 64'h55555555);
    clk(0, 0);
    chk("f2_we_low", 64'(im_we_o), 64'h0);
    chk("pulses2", 64'(pulses), 64'd2);

    dr_frame({12'h000, 32'h4AAAAA88, 1'b0}, 0, 0);
    clk(0, 0);
    chk("nw_addr", 64'(im_addr_o), 64'h000);
    chk("nw_data", 64'(im_data_o), 64'h4AAAAA88);
    chk("nw_pulses", 64'(pulses), 64'd2);
    tdo_cap = '0;
    dr_frame({12'h000, 32'h4AAAAA88, 1'b0}, 0, 0);
    chk("readback", tdo_cap, 64'({12'h000, 32'h4AAAAA88, 1'b0}));

    vv = 64'({12'h123, 32'hDEADBEEF, 1'b1});
    clk(1, 0);
    clk(0, 0);
    clk(0, 0);
    shift_bits(vv >> 25, 20, 1);
    clk(0, 0);
    repeat (3) clk(0, 0);
    clk(1, 0);
    clk(0, 0);
    shift_bits(vv, 25, 1);
    clk(1, 0);
    clk(0, 0);
    clk(0, 0);
    chk("pause_addr", 64'(im_addr_o), 64'h123);
    chk("pause_data", 64'(im_data_o), 64'hDEADBEEF);
    chk("pause_pulses", 64'(pulses), 64'd3);

    clk(1, 0);
    clk(0, 0);
    clk(0, 0);
    shift_bits(64'h3A5, 10, 0);
    trst_i = 1'b0;
    #1;
    chk("mid_addr", 64'(im_addr_o), 64'h0);
    chk("mid_data", 64'(im_data_o), 64'h0);
    chk("mid_we", 64'(im_we_o), 64'h0);
    chk("mid_sel", 64'(imem_sel_o), 64'h0);
    chk("mid_tdo", 64'(tdo_o), 64'h0);
    clk(0, 0);
    clk(0, 0);
    trst_i = 1'b1;
    clk(0, 0);
    chk("mid_pulses", 64'(pulses), 64'd3);

    ir_load80();
    chk("ir2_sel", 64'(imem_sel_o), 64'h1);
    clk(1, 0);
    clk(0, 0);
    clk(0, 0);
    repeat (5) clk(1, 0);
    clk(1, 0);
    chk("tlr_sel", 64'(imem_sel_o), 64'h0);

    clk(0, 0);
    clk(1, 0);
    clk(0, 0);
    clk(0, 0);
    tdo_cap = '0;
    shift_bits(64'hB, 4, 1);
    chk("bypass_tdo", tdo_cap & 64'hF, 64'h5);
    clk(1, 0);
    clk(0, 0);
    clk(0, 0);
    chk("bypass_pulses", 64'(pulses), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
